dram_arbiter: RTL



---
 rtl/dram_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin sharing of the single dram port between the
// instruction-fetch and data-access requesters, one transaction in flight,
// with a watchdog that errors out a stuck transaction and drains its late response.

package dram_arbiter_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef struct packed {
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic              mem_ready;
    logic              mem_error;
    logic [DATA_W-1:0] mem_rdata;
  } mem_out_type;
endpackage

module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  dram_in,
  input  mem_out_type dram_out
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic P_IMEM = 1'b0;
  localparam logic P_DMEM = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  mem_in_type  r_pend_i;
  mem_in_type  r_pend_d;
  mem_in_type  r_dram_in;
  logic        r_owner;
  logic        r_last;
  logic [CNT_W-1:0] r_cnt;

  logic        w_cand_i;
  logic        w_cand_d;
  logic        w_grant;
  logic        w_gnt_port;
  logic        w_done;
  logic        w_tmo;
  mem_in_type  w_req_i;
  mem_in_type  w_req_d;
  mem_in_type  w_gnt_req;
  mem_out_type w_resp;

  // A port competes if it has a buffered request or is pulsing this cycle
  assign w_cand_i = r_pend_i.mem_valid | imem_in.mem_valid;
  assign w_cand_d = r_pend_d.mem_valid | dmem_in.mem_valid;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, arbitration decision and combinational response routing
  always_comb begin
    w_state_nxt = r_state;
    w_req_i     = r_pend_i.mem_valid ? r_pend_i : imem_in;
    w_req_d     = r_pend_d.mem_valid ? r_pend_d : dmem_in;
    w_grant     = 1'b0;
    w_gnt_port  = P_IMEM;
    w_gnt_req   = '0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    w_resp      = '0;
    imem_out    = '0;
    dmem_out    = '0;

    case (r_state)
      S_IDLE: begin
        if (w_cand_i || w_cand_d) begin
          w_grant     = 1'b1;
          w_gnt_port  = (w_cand_i && w_cand_d) ? ~r_last : w_cand_d;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (dram_out.mem_ready) begin
          w_done      = 1'b1;
          w_resp      = dram_out;
          w_state_nxt = S_IDLE;
        end else if ((TIMEOUT != 0) && (r_cnt == TMO_LAST)) begin
          w_tmo            = 1'b1;
          w_resp.mem_ready = 1'b1;
          w_resp.mem_error = 1'b1;
          w_state_nxt      = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dram_out.mem_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_gnt_req           = (w_gnt_port == P_DMEM) ? w_req_d : w_req_i;
    w_gnt_req.mem_valid = 1'b1;

    if (r_owner == P_IMEM) imem_out = w_resp;
    else                   dmem_out = w_resp;
  end

  // Owner, round-robin history and saturating watchdog counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner <= P_IMEM;
      r_last  <= P_IMEM;
      r_cnt   <= '0;
    end else if (w_grant) begin
      r_owner <= w_gnt_port;
      r_last  <= w_gnt_port;
      r_cnt   <= '0;
    end else if ((r_state == S_BUSY) && !w_done && !w_tmo && (r_cnt != CNT_MAX)) begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Registered request to dram: one-cycle valid, payload held while busy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       r_dram_in           <= '0;
    else if (w_grant) r_dram_in           <= w_gnt_req;
    else              r_dram_in.mem_valid <= 1'b0;
  end

  // Instruction-port request buffer: cleared on completion, loaded when empty
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend_i <= '0;
    end else begin
      assert (!(imem_in.mem_valid && r_pend_i.mem_valid));
      if ((w_done || w_tmo) && (r_owner == P_IMEM)) r_pend_i <= '0;
      else if (imem_in.mem_valid && !r_pend_i.mem_valid) r_pend_i <= imem_in;
    end
  end

  // Data-port request buffer: cleared on completion, loaded when empty
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend_d <= '0;
    end else begin
      assert (!(dmem_in.mem_valid && r_pend_d.mem_valid));
      if ((w_done || w_tmo) && (r_owner == P_DMEM)) r_pend_d <= '0;
      else if (dmem_in.mem_valid && !r_pend_d.mem_valid) r_pend_d <= dmem_in;
    end
  end

  assign dram_in = r_dram_in;

endmodule
